// File: rtl/board_store.sv
//==============================================================================
// Module      : board_store
// Description : Authoritative 64-square board register. Loads the starting
//               position by a sequential sweep, applies user write commands,
//               and counts captures per side and completed move bursts.
//               Optional build macro: PIECE_CHECK_EN (content validation and
//               the badWrite sticky flag).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module board_store #(
    parameter int CAPTURE_W = 4,
    parameter int MOVE_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          changePiece,
    input  logic                 newGame,
    output logic [255:0]         entireBoard,
    output logic                 boardReady,
    output logic [CAPTURE_W-1:0] whiteCaptures,
    output logic [CAPTURE_W-1:0] blackCaptures,
    output logic [MOVE_W-1:0]    moveCount,
    output logic                 droppedWrite
`ifdef PIECE_CHECK_EN
    ,
    output logic                 badWrite
`endif
);

    localparam logic [2:0] c_EMPTY  = 3'd0;
    localparam logic [2:0] c_KING   = 3'd1;
    localparam logic [2:0] c_QUEEN  = 3'd2;
    localparam logic [2:0] c_BISHOP = 3'd3;
    localparam logic [2:0] c_KNIGHT = 3'd4;
    localparam logic [2:0] c_ROOK   = 3'd5;
    localparam logic [2:0] c_PAWN   = 3'd6;
    localparam logic       c_WHITE  = 1'b0;
    localparam logic       c_BLACK  = 1'b1;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [255:0]         r_board;
    logic [5:0]           r_idx;
    logic [CAPTURE_W-1:0] r_white;
    logic [CAPTURE_W-1:0] r_black;
    logic [MOVE_W-1:0]    r_moves;
    logic                 r_dropped;
    logic                 r_prevEn;

    logic                 w_wrEn;
    logic [5:0]           w_wrSquare;
    logic [3:0]           w_wrRaw;
    logic [3:0]           w_wrData;
    logic                 w_reject;
    logic [3:0]           w_oldNibble;
    logic                 w_sweepWrite;
    logic                 w_userWrite;
    logic                 w_dropSet;
    logic                 w_badSet;
    logic                 w_moveDone;
    logic                 w_capture;

    // Back-rank piece order by column, identical for both colours.
    function automatic logic [2:0] backRank(input logic [2:0] col);
        logic [2:0] piece;
        case (col)
            3'd0, 3'd7: piece = c_ROOK;
            3'd1, 3'd6: piece = c_KNIGHT;
            3'd2, 3'd5: piece = c_BISHOP;
            3'd3:       piece = c_QUEEN;
            default:    piece = c_KING;
        endcase
        return piece;
    endfunction

    // Square index is col*8 + row, so row lives in the low three bits.
    function automatic logic [3:0] startNibble(input logic [5:0] sq);
        logic [3:0] nib;
        case (sq[2:0])
            3'd0:    nib = {c_BLACK, backRank(sq[5:3])};
            3'd1:    nib = {c_BLACK, c_PAWN};
            3'd6:    nib = {c_WHITE, c_PAWN};
            3'd7:    nib = {c_WHITE, backRank(sq[5:3])};
            default: nib = {c_WHITE, c_EMPTY};
        endcase
        return nib;
    endfunction

    assign w_wrEn      = changePiece[10];
    assign w_wrRaw     = changePiece[9:6];
    assign w_wrSquare  = changePiece[5:0];
    assign w_oldNibble = r_board[{w_wrSquare, 2'b00} +: 4];

`ifdef PIECE_CHECK_EN
    assign w_wrData = (w_wrRaw == 4'b1000) ? 4'b0000 : w_wrRaw;
    assign w_reject = (w_wrRaw[2:0] == 3'd7);
`else
    assign w_wrData = w_wrRaw;
    assign w_reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_sweepWrite = 1'b0;
        w_userWrite  = 1'b0;
        w_dropSet    = 1'b0;
        w_badSet     = 1'b0;
        w_moveDone   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweepWrite = 1'b1;
                w_dropSet    = w_wrEn;
                if (r_idx == 6'd63) begin
                    w_nextState = ST_READY;
                end
            end
            default: begin
                w_userWrite = w_wrEn && !w_reject;
                w_badSet    = w_wrEn && w_reject;
                w_moveDone  = r_prevEn && !w_wrEn;
            end
        endcase
        // A new game wins over everything, including a write in the same cycle.
        if (newGame) begin
            w_nextState  = ST_INIT;
            w_sweepWrite = 1'b0;
            w_userWrite  = 1'b0;
            w_dropSet    = 1'b0;
            w_badSet     = 1'b0;
            w_moveDone   = 1'b0;
        end
    end

    // Captures need two real pieces of opposite colour; colour of the writer picks the side.
    assign w_capture = w_userWrite
                    && (w_oldNibble[2:0] != c_EMPTY)
                    && (w_wrData[2:0] != c_EMPTY)
                    && (w_oldNibble[3] != w_wrData[3]);

    always_ff @(posedge clk) begin
        if (!reset || newGame) begin
            r_board   <= '0;
            r_idx     <= '0;
            r_white   <= '0;
            r_black   <= '0;
            r_moves   <= '0;
            r_dropped <= 1'b0;
            r_prevEn  <= 1'b0;
        end else begin
            r_prevEn <= w_wrEn;
            if (w_sweepWrite) begin
                r_board[{r_idx, 2'b00} +: 4] <= startNibble(r_idx);
                r_idx                        <= r_idx + 6'd1;
            end
            if (w_userWrite) begin
                r_board[{w_wrSquare, 2'b00} +: 4] <= w_wrData;
            end
            if (w_dropSet) begin
                r_dropped <= 1'b1;
            end
            if (w_capture) begin
                if (w_wrData[3]) begin
                    if (r_black != {CAPTURE_W{1'b1}}) begin
                        r_black <= r_black + CAPTURE_W'(1);
                    end
                end else begin
                    if (r_white != {CAPTURE_W{1'b1}}) begin
                        r_white <= r_white + CAPTURE_W'(1);
                    end
                end
            end
            if (w_moveDone && (r_moves != {MOVE_W{1'b1}})) begin
                r_moves <= r_moves + MOVE_W'(1);
            end
        end
    end

`ifdef PIECE_CHECK_EN
    logic r_bad;

    always_ff @(posedge clk) begin
        if (!reset || newGame) begin
            r_bad <= 1'b0;
        end else if (w_badSet) begin
            r_bad <= 1'b1;
        end
    end

    assign badWrite = r_bad;
`endif

    assign entireBoard   = r_board;
    assign boardReady    = (r_state == ST_READY);
    assign whiteCaptures = r_white;
    assign blackCaptures = r_black;
    assign moveCount     = r_moves;
    assign droppedWrite  = r_dropped;

endmodule

`default_nettype wire
